pn_event_router: RTL and testbench

Parametrised neuron-core controller. It sits between the AXI-facing command path and the per-core Synapse, SOMA and STDP memories, and decodes each command word into registered single-cycle write or read strobes. It arbitrates synapse-weight writes coming back from the STDP update engine (SWU) against host commands. It expands a two-neuron spike command into two back-to-back synapse reads, using a small FSM with valid/ready handshakes on both inputs.

---
 rtl/pn_pkg.sv | 35 +++
 rtl/pn_cmd_decode.sv | 42 ++++
 rtl/pn_event_router.sv | 122 ++++++++++++
 tb/tb_pn_event_router.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pn_pkg.sv
// Shared encodings, FSM state type and command-field positions for the neuron-core event router.
package pn_pkg;

  localparam logic [1:0] SEL_RSVD = 2'b00;
  localparam logic [1:0] SEL_SYN  = 2'b01;
  localparam logic [1:0] SEL_SOMA = 2'b10;
  localparam logic [1:0] SEL_STDP = 2'b11;

  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

  // One-hot decoded command target
  localparam int unsigned TGT_W      = 5;
  localparam int unsigned TGT_SYN_WR = 0;
  localparam int unsigned TGT_SOMA   = 1;
  localparam int unsigned TGT_STDP   = 2;
  localparam int unsigned TGT_SYN_RD = 3;
  localparam int unsigned TGT_RSVD   = 4;

  function automatic int unsigned p_bit(input int unsigned na_w);
    return 2 * na_w + 1;
  endfunction

  function automatic int unsigned r_bit(input int unsigned na_w);
    return 2 * na_w;
  endfunction

  function automatic int unsigned sel_lo(input int unsigned na_w);
    return 2 * na_w - 2;
  endfunction

  function automatic int unsigned n1_lo(input int unsigned na_w);
    return na_w;
  endfunction

endpackage

// File: rtl/pn_cmd_decode.sv
// Combinational command-word decoder: one-hot target, two-neuron spike flag and neuron addresses.
module pn_cmd_decode
  import pn_pkg::*;
#(
  parameter int unsigned NA_W  = 7,
  parameter int unsigned CMD_W = 2 * NA_W + 2
) (
  input  logic [CMD_W-1:0] cmd_addr,
  output logic [TGT_W-1:0] target,
  output logic             two_spike,
  output logic [NA_W-1:0]  n0,
  output logic [NA_W-1:0]  n1
);

  localparam int unsigned PBit  = p_bit(NA_W);
  localparam int unsigned RBit  = r_bit(NA_W);
  localparam int unsigned SelLo = sel_lo(NA_W);
  localparam int unsigned N1Lo  = n1_lo(NA_W);

  logic [1:0] sel;

  always_comb begin
    n0        = cmd_addr[NA_W-1:0];
    n1        = cmd_addr[N1Lo +: NA_W];
    sel       = cmd_addr[SelLo +: 2];
    target    = '0;
    two_spike = 1'b0;
    if (cmd_addr[PBit]) begin
      unique case (sel)
        SEL_SYN:  target[TGT_SYN_WR] = 1'b1;
        SEL_SOMA: target[TGT_SOMA]   = 1'b1;
        SEL_STDP: target[TGT_STDP]   = 1'b1;
        default:  target[TGT_RSVD]   = 1'b1;
      endcase
    end else begin
      target[TGT_SYN_RD] = 1'b1;
      // Rich-club spikes and N1==0 collapse to a single read
      two_spike = !cmd_addr[RBit] && (n1 != '0);
    end
  end

endmodule

// File: rtl/pn_event_router.sv
// Neuron-core controller: registers decoded host commands and STDP weight updates into memory
// strobes, splitting two-neuron spikes into back-to-back synapse reads.
module pn_event_router
  import pn_pkg::*;
#(
  parameter int unsigned NA_W   = 7,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SWU_W  = 8,
  parameter int unsigned CMD_W  = 2 * NA_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              swu_valid,
  output logic              swu_ready,
  input  logic [NA_W-1:0]   swu_addr,
  input  logic [SWU_W-1:0]  swu_data,
  output logic              syn_we,
  output logic              syn_re,
  output logic [NA_W-1:0]   syn_addr,
  output logic [DATA_W-1:0] syn_wdata,
  output logic              soma_we,
  output logic [DATA_W-1:0] soma_wdata,
  output logic              stdp_we,
  output logic [NA_W-1:0]   stdp_addr,
  output logic [DATA_W-1:0] stdp_wdata,
  output logic              busy,
  output logic              err
);

  state_t            state_q;
  logic [NA_W-1:0]   n1_q;
  logic [TGT_W-1:0]  target;
  logic              two_spike;
  logic [NA_W-1:0]   n0;
  logic [NA_W-1:0]   n1;

  pn_cmd_decode #(
    .NA_W  (NA_W),
    .CMD_W (CMD_W)
  ) u_decode (
    .cmd_addr  (cmd_addr),
    .target    (target),
    .two_spike (two_spike),
    .n0        (n0),
    .n1        (n1)
  );

  // SWU always wins over host commands while idle
  assign swu_ready = (state_q == IDLE);
  assign cmd_ready = (state_q == IDLE) & ~swu_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      n1_q       <= '0;
      syn_we     <= 1'b0;
      syn_re     <= 1'b0;
      syn_addr   <= '0;
      syn_wdata  <= '0;
      soma_we    <= 1'b0;
      soma_wdata <= '0;
      stdp_we    <= 1'b0;
      stdp_addr  <= '0;
      stdp_wdata <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      syn_we     <= 1'b0;
      syn_re     <= 1'b0;
      syn_addr   <= '0;
      syn_wdata  <= '0;
      soma_we    <= 1'b0;
      soma_wdata <= '0;
      stdp_we    <= 1'b0;
      stdp_addr  <= '0;
      stdp_wdata <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (swu_valid) begin
            syn_we    <= 1'b1;
            syn_addr  <= swu_addr;
            syn_wdata <= DATA_W'(swu_data);
          end else if (cmd_valid) begin
            if (two_spike) begin
              state_q  <= SECOND;
              n1_q     <= n1;
              busy     <= 1'b1;
              syn_re   <= 1'b1;
              syn_addr <= n0;
            end else begin
              syn_we  <= target[TGT_SYN_WR];
              syn_re  <= target[TGT_SYN_RD];
              soma_we <= target[TGT_SOMA];
              stdp_we <= target[TGT_STDP];
              err     <= target[TGT_RSVD];
              if (target[TGT_SYN_WR] | target[TGT_SYN_RD]) syn_addr <= n0;
              if (target[TGT_SYN_WR]) syn_wdata <= cmd_data;
              if (target[TGT_SOMA]) soma_wdata <= cmd_data;
              if (target[TGT_STDP]) begin
                stdp_addr  <= n0;
                stdp_wdata <= cmd_data;
              end
            end
          end
        end
        SECOND: begin
          syn_re   <= 1'b1;
          syn_addr <= n1_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pn_event_router.sv
// Self-checking bench for pn_event_router: directed scenarios plus randomized traffic against a
// queue-based reference model.
module tb_pn_event_router;

  localparam int unsigned NA_W   = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SWU_W  = 8;
  localparam int unsigned CMD_W  = 16;

  typedef struct packed {
    logic        syn_we;
    logic        syn_re;
    logic [6:0]  syn_addr;
    logic [31:0] syn_wdata;
    logic        soma_we;
    logic [31:0] soma_wdata;
    logic        stdp_we;
    logic [6:0]  stdp_addr;
    logic [31:0] stdp_wdata;
    logic        busy;
    logic        err;
  } out_t;

  typedef struct {
    logic        sv;
    logic [6:0]  sa;
    logic [7:0]  sd;
    logic        cv;
    logic [15:0] ca;
    logic [31:0] cd;
  } stim_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [CMD_W-1:0]  cmd_addr = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              swu_valid = 1'b0;
  logic              swu_ready;
  logic [NA_W-1:0]   swu_addr = '0;
  logic [SWU_W-1:0]  swu_data = '0;
  logic              syn_we, syn_re, soma_we, stdp_we, busy, err;
  logic [NA_W-1:0]   syn_addr, stdp_addr;
  logic [DATA_W-1:0] syn_wdata, soma_wdata, stdp_wdata;

  out_t obs;
  int   tests = 0;
  int   fails = 0;
  logic [6:0] pending[$];

  always #5 clk = ~clk;

  assign obs = {syn_we, syn_re, syn_addr, syn_wdata, soma_we, soma_wdata, stdp_we, stdp_addr,
                stdp_wdata, busy, err};

  pn_event_router #(
    .NA_W   (NA_W),
    .DATA_W (DATA_W),
    .SWU_W  (SWU_W),
    .CMD_W  (CMD_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .swu_valid  (swu_valid),
    .swu_ready  (swu_ready),
    .swu_addr   (swu_addr),
    .swu_data   (swu_data),
    .syn_we     (syn_we),
    .syn_re     (syn_re),
    .syn_addr   (syn_addr),
    .syn_wdata  (syn_wdata),
    .soma_we    (soma_we),
    .soma_wdata (soma_wdata),
    .stdp_we    (stdp_we),
    .stdp_addr  (stdp_addr),
    .stdp_wdata (stdp_wdata),
    .busy       (busy),
    .err        (err)
  );

  function automatic stim_t mk(input logic sv, input logic [6:0] sa, input logic [7:0] sd,
                               input logic cv, input logic [15:0] ca, input logic [31:0] cd);
    stim_t s;
    s.sv = sv; s.sa = sa; s.sd = sd; s.cv = cv; s.ca = ca; s.cd = cd;
    return s;
  endfunction

  // Drives one cycle of stimulus, samples readies mid-cycle and predicts the registered outputs.
  // A pending second-neuron read is modelled as a queue entry that owns the next cycle.
  task automatic step(input stim_t s, output out_t e, output logic [1:0] ro, output logic [1:0] rx);
    int unsigned c, p, r, sel, n0, n1;
    @(negedge clk);
    swu_valid = s.sv; swu_addr = s.sa; swu_data = s.sd;
    cmd_valid = s.cv; cmd_addr = s.ca; cmd_data = s.cd;
    #1;
    ro = {swu_ready, cmd_ready};
    rx = {pending.size() == 0, (pending.size() == 0) && !s.sv};
    e = '0;
    c = s.ca; p = c / 32768; r = (c / 16384) % 2; sel = (c / 4096) % 4;
    n0 = c % 128; n1 = (c / 128) % 128;
    if (pending.size() != 0) begin
      e.syn_re   = 1'b1;
      e.syn_addr = pending.pop_front();
    end else if (s.sv) begin
      e.syn_we    = 1'b1;
      e.syn_addr  = s.sa;
      e.syn_wdata = {24'd0, s.sd};
    end else if (s.cv) begin
      if (p == 1) begin
        case (sel)
          1: begin e.syn_we = 1'b1; e.syn_addr = 7'(n0); e.syn_wdata = s.cd; end
          2: begin e.soma_we = 1'b1; e.soma_wdata = s.cd; end
          3: begin e.stdp_we = 1'b1; e.stdp_addr = 7'(n0); e.stdp_wdata = s.cd; end
          default: e.err = 1'b1;
        endcase
      end else begin
        e.syn_re   = 1'b1;
        e.syn_addr = 7'(n0);
        if (r == 0 && n1 != 0) begin
          pending.push_back(7'(n1));
          e.busy = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    tests++;
    if (obs !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", obs);
    end
    tests++;
    if ({swu_ready, cmd_ready} !== 2'b11) begin
      fails++; $display("FAIL reset_ready: got %b want 11", {swu_ready, cmd_ready});
    end
    swu_valid = 1'b1;
    #1;
    tests++;
    if ({swu_ready, cmd_ready} !== 2'b10) begin
      fails++; $display("FAIL reset_ready_swu: got %b want 10", {swu_ready, cmd_ready});
    end
    swu_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_param_writes();
    stim_t seq[$]; out_t e; logic [1:0] ro, rx;
    seq.push_back(mk(0, 0, 0, 1, 16'hA005, 32'h12345678)); // SEL=10: SOMA
    seq.push_back(mk(0, 0, 0, 1, 16'hB005, 32'h12345678)); // SEL=11: STDP addr 5
    seq.push_back(mk(0, 0, 0, 1, 16'h9002, 32'hDEADBEEF)); // SEL=01: synapse write addr 2
    seq.push_back(mk(0, 0, 0, 0, 16'h0000, 32'h0));
    foreach (seq[i]) begin
      step(seq[i], e, ro, rx);
      tests++;
      if (ro !== rx) begin
        fails++; $display("FAIL param_ready step %0d: got %b want %b", i, ro, rx);
      end
      tests++;
      if (obs !== e) begin
        fails++; $display("FAIL param_out step %0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_two_spike();
    stim_t seq[$]; out_t e; logic [1:0] ro, rx;
    seq.push_back(mk(0, 0, 0, 1, 16'h0183, 32'h0));
    seq.push_back(mk(0, 0, 0, 1, 16'h9002, 32'h55)); // offered during SECOND, must wait
    seq.push_back(mk(0, 0, 0, 1, 16'h9002, 32'h55));
    seq.push_back(mk(0, 0, 0, 0, 16'h0000, 32'h0));
    foreach (seq[i]) begin
      step(seq[i], e, ro, rx);
      tests++;
      if (ro !== rx) begin
        fails++; $display("FAIL two_spike_ready step %0d: got %b want %b", i, ro, rx);
      end
      tests++;
      if (obs !== e) begin
        fails++; $display("FAIL two_spike_out step %0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_rich_club();
    stim_t seq[$]; out_t e; logic [1:0] ro, rx;
    seq.push_back(mk(0, 0, 0, 1, 16'h4183, 32'h0));
    seq.push_back(mk(0, 0, 0, 1, 16'h0005, 32'h0)); // N1==0: single read too
    seq.push_back(mk(0, 0, 0, 0, 16'h0000, 32'h0));
    foreach (seq[i]) begin
      step(seq[i], e, ro, rx);
      tests++;
      if (ro !== rx) begin
        fails++; $display("FAIL rich_club_ready step %0d: got %b want %b", i, ro, rx);
      end
      tests++;
      if (obs !== e) begin
        fails++; $display("FAIL rich_club_out step %0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_swu_priority();
    stim_t seq[$]; out_t e; logic [1:0] ro, rx;
    seq.push_back(mk(1, 7'h11, 8'hAB, 1, 16'h9002, 32'hCAFEF00D));
    seq.push_back(mk(0, 7'h00, 8'h00, 1, 16'h9002, 32'hCAFEF00D));
    seq.push_back(mk(0, 7'h00, 8'h00, 1, 16'h0285, 32'h0));
    seq.push_back(mk(1, 7'h3C, 8'hFF, 0, 16'h0000, 32'h0)); // arrives during SECOND
    seq.push_back(mk(1, 7'h3C, 8'hFF, 0, 16'h0000, 32'h0));
    seq.push_back(mk(0, 7'h00, 8'h00, 0, 16'h0000, 32'h0));
    foreach (seq[i]) begin
      step(seq[i], e, ro, rx);
      tests++;
      if (ro !== rx) begin
        fails++; $display("FAIL swu_prio_ready step %0d: got %b want %b", i, ro, rx);
      end
      tests++;
      if (obs !== e) begin
        fails++; $display("FAIL swu_prio_out step %0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_reserved_and_reset();
    out_t e; logic [1:0] ro, rx;
    step(mk(0, 0, 0, 1, 16'h8000, 32'hFFFFFFFF), e, ro, rx);
    tests++;
    if (obs !== e || e.err !== 1'b1) begin
      fails++; $display("FAIL reserved_out: got %h want %h", obs, e);
    end
    step(mk(0, 0, 0, 0, 16'h0000, 32'h0), e, ro, rx);
    tests++;
    if (obs !== e) begin
      fails++; $display("FAIL reserved_clear: got %h want %h", obs, e);
    end
    step(mk(0, 0, 0, 1, 16'h0183, 32'h0), e, ro, rx);
    tests++;
    if (obs !== e) begin
      fails++; $display("FAIL rst_second_entry: got %h want %h", obs, e);
    end
    // Mid-SECOND: reset drops the pending N1 read
    cmd_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    pending.delete();
    tests++;
    if (obs !== '0) begin
      fails++; $display("FAIL rst_second_out: got %h want 0", obs);
    end
    tests++;
    if ({swu_ready, cmd_ready} !== 2'b11) begin
      fails++; $display("FAIL rst_second_ready: got %b want 11", {swu_ready, cmd_ready});
    end
    @(negedge clk);
    rst = 1'b1;
    step(mk(0, 0, 0, 0, 16'h0000, 32'h0), e, ro, rx);
    tests++;
    if (obs !== e || ro !== rx) begin
      fails++; $display("FAIL rst_second_after: got %h/%b want %h/%b", obs, ro, e, rx);
    end
  endtask

  task automatic test_random();
    stim_t s; out_t e; logic [1:0] ro, rx; logic held;
    held = 1'b0;
    s = mk(0, 0, 0, 0, 16'h0000, 32'h0);
    for (int i = 0; i < 400; i++) begin
      s.sv = ($urandom_range(3) == 0);
      s.sa = 7'($urandom);
      s.sd = 8'($urandom);
      if (!held) begin
        s.cv = 1'($urandom_range(1));
        s.ca = 16'($urandom);
        s.cd = $urandom;
      end
      step(s, e, ro, rx);
      held = s.cv && !rx[0];
      tests++;
      if (ro !== rx) begin
        fails++; $display("FAIL random_ready step %0d: got %b want %b", i, ro, rx);
      end
      tests++;
      if (obs !== e) begin
        fails++; $display("FAIL random_out step %0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_param_writes();
    test_two_spike();
    test_rich_club();
    test_swu_priority();
    test_reserved_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
